// File: rtl/fp_pkg.sv
// Shared constants, field positions and controller state encoding for the
// sequential single-precision adder.
package fp_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;

  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_align_stage.sv
// Combinational operand swap, exponent difference and alignment shift of the
// smaller operand's mantissa, saturating to zero once the gap exceeds its width.
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_pkg::MANT_W
) (
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  big_sign,
  output logic                  eff_sub,
  output logic [EXP_W-1:0]      big_exp,
  output logic [MANT_W:0]       big_mant,
  output logic [MANT_W:0]       little_mant
);

  localparam logic [EXP_W-1:0] SHIFT_SAT = EXP_W'(MANT_W + 1);

  logic                    swap;
  logic [EXP_W+MANT_W:0]   big_op;
  logic [EXP_W+MANT_W:0]   little_op;
  logic [EXP_W-1:0]        little_exp;
  logic [EXP_W-1:0]        diff;
  logic [MANT_W:0]         little_full;

  // Magnitude compare on {exp,mant}; ties keep A as the big operand.
  assign swap      = b[EXP_W+MANT_W-1:0] > a[EXP_W+MANT_W-1:0];
  assign big_op    = swap ? b : a;
  assign little_op = swap ? a : b;

  assign big_sign   = big_op[EXP_W+MANT_W];
  assign eff_sub    = big_op[EXP_W+MANT_W] ^ little_op[EXP_W+MANT_W];
  assign big_exp    = big_op[EXP_W+MANT_W-1:MANT_W];
  assign little_exp = little_op[EXP_W+MANT_W-1:MANT_W];
  assign diff       = big_exp - little_exp;

  assign big_mant    = (big_exp == '0) ? '0 : {1'b1, big_op[MANT_W-1:0]};
  assign little_full = (little_exp == '0) ? '0 : {1'b1, little_op[MANT_W-1:0]};
  assign little_mant = (diff >= SHIFT_SAT) ? '0 : (little_full >> diff);

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle IEEE-754 single adder: CMP, ALIGN, ADD, iterative NORM, DONE,
// with valid/ready handshakes and truncating normalisation.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = fp_pkg::EXP_W,
  parameter int unsigned MANT_W = fp_pkg::MANT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MANT_W:0] a,
  input  logic [EXP_W+MANT_W:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic                  busy
);

  localparam logic [EXP_W-1:0] EXP_CARRY_MAX = EXP_W'((1 << EXP_W) - 2);

  state_t state, state_nxt;

  logic [EXP_W+MANT_W:0] op_a, op_b;
  logic                  st_sign, st_sub;
  logic [EXP_W-1:0]      st_exp;
  logic [MANT_W:0]       st_big, st_little;

  logic                  c_sign, c_sub;
  logic [EXP_W-1:0]      c_exp;
  logic [MANT_W:0]       c_big, c_little;

  logic                  sign_w;
  logic [EXP_W-1:0]      exp_w;
  logic [MANT_W+1:0]     sum;

  fp_align_stage #(
    .EXP_W (EXP_W),
    .MANT_W(MANT_W)
  ) u_align (
    .a          (op_a),
    .b          (op_b),
    .big_sign   (st_sign),
    .eff_sub    (st_sub),
    .big_exp    (st_exp),
    .big_mant   (st_big),
    .little_mant(st_little)
  );

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_valid) state_nxt = CMP;
      CMP:   state_nxt = ALIGN;
      ALIGN: state_nxt = ADD;
      ADD:   state_nxt = NORM;
      NORM:  if (sum == '0 || sum[MANT_W+1] || sum[MANT_W] || exp_w <= EXP_W'(1))
               state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The aligned mantissa is captured in CMP; ALIGN loads the working exponent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (in_valid) begin
          op_a <= a;
          op_b <= b;
        end
        CMP: begin
          c_sign   <= st_sign;
          c_sub    <= st_sub;
          c_exp    <= st_exp;
          c_big    <= st_big;
          c_little <= st_little;
        end
        ALIGN: exp_w <= c_exp;
        ADD: begin
          sign_w <= c_sign;
          sum    <= c_sub ? ({1'b0, c_big} - {1'b0, c_little})
                          : ({1'b0, c_big} + {1'b0, c_little});
        end
        NORM: begin
          if (sum == '0) begin
            result <= '0;
          end else if (sum[MANT_W+1]) begin
            if (exp_w >= EXP_CARRY_MAX)
              result <= {sign_w, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            else
              result <= {sign_w, exp_w + EXP_W'(1), sum[MANT_W:1]};
          end else if (sum[MANT_W]) begin
            result <= {sign_w, exp_w, sum[MANT_W-1:0]};
          end else if (exp_w <= EXP_W'(1)) begin
            result <= '0;
          end else begin
            sum   <= sum << 1;
            exp_w <= exp_w - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed self-checking bench for fp_add_sequencer: values, latency,
// backpressure and mid-operation reset.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fp_add_sequencer #(
    .EXP_W (8),
    .MANT_W(23)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Issues one operation from IDLE and returns when out_valid is first seen
  // (or the cycle budget expires); lat counts cycles after the acceptance edge.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 00000000", result); end
  endtask

  task automatic test_vectors();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vr [7];
    int          vl [7];
    logic [31:0] res;
    int          lat;
    // 1.5+2.5, 1.0-0.75, cancel, big gap, overflow, flush, zero-exp operand
    va[0] = 32'h3FC00000; vb[0] = 32'h40200000; vr[0] = 32'h40800000; vl[0] = 5;
    va[1] = 32'h3F800000; vb[1] = 32'hBF400000; vr[1] = 32'h3E800000; vl[1] = 7;
    va[2] = 32'h3F800000; vb[2] = 32'hBF800000; vr[2] = 32'h00000000; vl[2] = 5;
    va[3] = 32'h3F800000; vb[3] = 32'h30800000; vr[3] = 32'h3F800000; vl[3] = 5;
    va[4] = 32'h7F7FFFFF; vb[4] = 32'h7F7FFFFF; vr[4] = 32'h7F800000; vl[4] = 5;
    va[5] = 32'h00800000; vb[5] = 32'h80C00000; vr[5] = 32'h00000000; vl[5] = 5;
    va[6] = 32'h00400000; vb[6] = 32'h40400000; vr[6] = 32'h40400000; vl[6] = 5;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], res, lat);
      checks++;
      if (res !== vr[i]) begin
        errors++; $display("FAIL vec%0d_result got %h exp %h", i, res, vr[i]);
      end
      checks++;
      if (lat !== vl[i]) begin
        errors++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, vl[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    out_ready = 1'b0;
    do_op(32'h3FC00000, 32'h40200000, res, lat);
    checks++; if (res !== 32'h40800000) begin errors++; $display("FAIL bp_result got %h exp 40800000", res); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h40800000 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b r=%h ir=%b busy=%b exp v=1 r=40800000 ir=0 busy=1",
                 i, out_valid, result, in_ready, busy);
      end
      @(posedge clk); #1;
    end
    release_op();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_reset_in_norm();
    logic [31:0] res;
    int          lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'hBF400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstnorm_valid got %b exp 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstnorm_result got %h exp 00000000", result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstnorm_ready got %b exp 1", in_ready); end
    do_op(32'h3FC00000, 32'h40200000, res, lat);
    checks++; if (res !== 32'h40800000) begin errors++; $display("FAIL rstnorm_after got %h exp 40800000", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstnorm_after_lat got %0d exp 5", lat); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_in_norm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
